// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard/stall controller for the 16-bit five-stage core.
//            Drives PC and pipeline-register write enables, NOP injection
//            for IF/ID and ID/EX, and holds a taken redirect pending behind
//            an outstanding instruction fetch.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_vld,
    input  logic        id_rt_vld,
    input  logic [2:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic [15:0] ex_target,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pc_target_sel,
    output logic [15:0] pc_target,
    output logic [15:0] stall_cnt,
    output logic        err
);

    // One-hot style encoding so that 00/11 are detectable as corrupt states
    typedef enum logic [1:0] {
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_saved_tgt;
    logic        w_save_tgt;
    logic [15:0] r_stall_cnt;
    logic        w_lu;

    assign w_lu = ex_is_load & ((id_rs_vld & (id_rs == ex_rd)) |
                                (id_rt_vld & (id_rt == ex_rd)));

    assign stall_cnt = r_stall_cnt;

    // Next-state and all pipeline control outputs, by priority
    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pc_target_sel = 1'b0;
        pc_target     = ex_target;
        err           = 1'b0;
        w_save_tgt    = 1'b0;
        w_state_nxt   = r_state;

        if (rst) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (dmem_stall) begin
                        // Whole pipe frozen; EX events will re-present later
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else if (ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (imem_stall) begin
                            // Fetch still outstanding: remember the target
                            pc_en       = 1'b0;
                            w_save_tgt  = 1'b1;
                            w_state_nxt = ST_PEND;
                        end else begin
                            pc_target_sel = 1'b1;
                        end
                    end else if (w_lu) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (imem_stall) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                ST_PEND: begin
                    pc_target = r_saved_tgt;
                    if (dmem_stall) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else begin
                        // ID/EX already holds a bubble; keep squashing
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (imem_stall) begin
                            pc_en = 1'b0;
                        end else begin
                            pc_target_sel = 1'b1;
                            w_state_nxt   = ST_RUN;
                        end
                    end
                end
                default: begin
                    err         = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State and saved redirect target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_saved_tgt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_save_tgt) begin
                r_saved_tgt <= ex_target;
            end
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (!pc_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_stall;
    logic        dmem_stall;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_rs_vld;
    logic        id_rt_vld;
    logic [2:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_redirect;
    logic [15:0] ex_target;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pc_target_sel;
    logic [15:0] pc_target;
    logic [15:0] stall_cnt;
    logic        err;

    hazard_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_stall    (imem_stall),
        .dmem_stall    (dmem_stall),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_vld     (id_rs_vld),
        .id_rt_vld     (id_rt_vld),
        .ex_rd         (ex_rd),
        .ex_is_load    (ex_is_load),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pc_target_sel (pc_target_sel),
        .pc_target     (pc_target),
        .stall_cnt     (stall_cnt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b1;

    // Reference model state: is a redirect waiting, and for where
    bit          m_pending;
    logic [15:0] m_tgt;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; imem_stall = 0; dmem_stall = 0;
        id_rs = 3'd0; id_rt = 3'd0; id_rs_vld = 0; id_rt_vld = 0;
        ex_rd = 3'd7; ex_is_load = 0; ex_redirect = 0; ex_target = 16'h0000;
    endtask

    // Compare one cycle's outputs against the model, then advance the model
    task automatic cycle();
        bit lu;
        bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_flush, e_bub, e_sel;
        logic [15:0] e_tgt;
        @(negedge clk);
        lu = ex_is_load && ((id_rs_vld && id_rs == ex_rd) || (id_rt_vld && id_rt == ex_rd));
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        {e_flush, e_bub, e_sel} = 3'b000;
        e_tgt = (m_pending && !rst) ? m_tgt : ex_target;
        if (rst) begin
            // defaults
        end else if (dmem_stall) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
        end else if (m_pending || ex_redirect) begin
            e_flush = 1; e_bub = 1;
            e_pc = !imem_stall; e_sel = !imem_stall;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else if (imem_stall) begin
            e_pc = 0; e_flush = 1;
        end
        if (chk_on) begin
            chk("enables", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en},
                {27'd0, e_pc, e_ifid, e_idex, e_exmem, e_memwb});
            chk("flush_bubble_sel", {29'd0, ifid_flush, idex_bubble, pc_target_sel},
                {29'd0, e_flush, e_bub, e_sel});
            chk("pc_target", {16'd0, pc_target}, {16'd0, e_tgt});
            chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
            chk("err", {31'd0, err}, 32'd0);
        end
        @(posedge clk);
        if (rst) begin
            m_pending = 0; m_tgt = 16'h0; m_cnt = 0;
        end else begin
            if (!e_pc && m_cnt < 65535) m_cnt++;
            if (!dmem_stall) begin
                if (m_pending && !imem_stall) m_pending = 0;
                else if (!m_pending && ex_redirect && imem_stall) begin
                    m_pending = 1; m_tgt = ex_target;
                end
            end
        end
        #1;
    endtask

    initial begin
        m_pending = 0; m_tgt = 16'h0; m_cnt = 0;
        idle_inputs();
        #1;

        // Reset held for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            {imem_stall, dmem_stall, id_rs_vld, id_rt_vld, ex_is_load, ex_redirect} = 6'($urandom);
            id_rs = 3'($urandom); id_rt = 3'($urandom); ex_rd = 3'($urandom);
            ex_target = 16'($urandom);
            rst = 1;
            cycle();
        end
        idle_inputs();
        cycle();

        // Load-use on rt, then same with rt not read
        ex_is_load = 1; ex_rd = 3'd3; id_rt = 3'd3; id_rt_vld = 1;
        cycle();
        chk("lu_cnt_1", {16'd0, stall_cnt}, 32'd1);
        id_rt_vld = 0;
        cycle();
        idle_inputs();
        cycle();

        // Redirect with fetch idle
        ex_redirect = 1; ex_target = 16'h0040;
        cycle();
        idle_inputs();
        cycle();

        // Redirect under a three-cycle fetch stall
        imem_stall = 1; ex_redirect = 1; ex_target = 16'h1234;
        cycle();
        ex_redirect = 0; ex_target = 16'hBEEF;
        cycle();
        ex_target = 16'h5555;
        cycle();
        imem_stall = 0; ex_target = 16'hAAAA;
        chk("pend_tgt", {16'd0, pc_target}, 32'h1234);
        cycle();
        idle_inputs();
        cycle();

        // Data stall beats redirect and load-use
        dmem_stall = 1; ex_redirect = 1; ex_is_load = 1; ex_rd = 3'd2; id_rs = 3'd2; id_rs_vld = 1;
        cycle();
        idle_inputs();
        cycle();
        // Data stall while pending: frozen, stays pending
        imem_stall = 1; ex_redirect = 1; ex_target = 16'h0F0F;
        cycle();
        ex_redirect = 0; ex_target = 16'h0000; dmem_stall = 1; imem_stall = 0;
        cycle();
        cycle();
        dmem_stall = 0;
        chk("pend_after_dmem", {16'd0, pc_target}, 32'h0F0F);
        cycle();
        idle_inputs();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            imem_stall  = ($urandom_range(0, 99) < 40);
            dmem_stall  = ($urandom_range(0, 99) < 15);
            ex_redirect = ($urandom_range(0, 99) < 25);
            ex_is_load  = $urandom_range(0, 1);
            id_rs_vld   = $urandom_range(0, 1);
            id_rt_vld   = $urandom_range(0, 1);
            id_rs = 3'($urandom); id_rt = 3'($urandom); ex_rd = 3'($urandom);
            ex_target = 16'($urandom);
            cycle();
        end

        // Saturation: hold the PC for more than 65535 cycles
        rst = 1; cycle();
        idle_inputs();
        dmem_stall = 1;
        chk_on = 0;
        for (int i = 0; i < 65537; i++) cycle();
        chk_on = 1;
        cycle();
        chk("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
        rst = 1; cycle();
        rst = 0; dmem_stall = 0;
        chk("cnt_after_rst", {16'd0, stall_cnt}, 32'h0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit five-stage core. It drives the write enables of the PC and the four pipeline registers, which are enabled 16-bit flops. It also drives the NOP-injection controls for IF/ID and ID/EX. It resolves data-memory stalls, load-use hazards, instruction-memory stalls and taken branches/jumps from EX. A taken redirect that arrives while a fetch is still outstanding is held in a pending state with a saved target.

## Interface
Parameters:
- none (datapath width fixed at 16, register specifiers fixed at 3 bits)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_stall  in  1  instruction fetch not complete this cycle
- dmem_stall  in  1  data-memory access in MEM not complete this cycle
- id_rs, id_rt  in  3 each  source register specifiers of instruction in ID
- id_rs_vld, id_rt_vld  in  1 each  corresponding source is actually read
- ex_rd  in  3  destination specifier of instruction in EX
- ex_is_load  in  1  instruction in EX is a load
- ex_redirect  in  1  branch/jump resolved taken in EX
- ex_target  in  16  redirect target from EX
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write enables
- ifid_flush  out  1  IF/ID loads NOP instead of fetched instruction
- idex_bubble  out  1  ID/EX loads NOP instead of decoded instruction
- pc_target_sel  out  1  PC loads pc_target instead of PC+2
- pc_target  out  16  target for PC when pc_target_sel=1
- stall_cnt  out  16  saturating count of cycles with pc_en=0
- err  out  1  illegal internal state

## Operation
- State machine: RUN (normal) and PEND (redirect pending behind an outstanding fetch). Any other state encoding sets err=1 and forces RUN on the next edge.
- Load-use hazard: lu = ex_is_load & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
- Default (RUN, no event): all enables 1, flush/bubble 0, pc_target_sel 0.
- Priority, highest first:
  1. dmem_stall: all five enables 0; flush, bubble and pc_target_sel are 0; state and saved target unchanged. ex_redirect and lu are ignored because EX is frozen and they will re-present.
  2. RUN & ex_redirect & !imem_stall: pc_en=1, pc_target_sel=1, pc_target=ex_target, ifid_flush=1, idex_bubble=1.
  3. RUN & ex_redirect & imem_stall: pc_en=0, ifid_flush=1, idex_bubble=1; save ex_target; go to PEND.
  4. RUN & lu: pc_en=0, ifid_en=0, idex_bubble=1; other enables 1. This applies regardless of imem_stall.
  5. RUN & imem_stall: pc_en=0, ifid_flush=1; other enables 1.
- PEND with !dmem_stall: ex_redirect and lu are ignored because ID/EX already holds a bubble. ifid_flush=1 and idex_bubble=1 every cycle.
  - While imem_stall: pc_en=0.
  - When imem_stall=0: pc_en=1, pc_target_sel=1, pc_target=saved target; go to RUN.
- pc_target = saved target in PEND, otherwise ex_target.
- stall_cnt increments on every non-reset cycle with pc_en=0 and saturates at 0xFFFF.

## Timing
- Enables, flush, bubble, pc_target and pc_target_sel are combinational from the current state and inputs, with zero latency. State, saved target and stall_cnt are registered.
- While rst=1:
  - All enables are 1.
  - ifid_flush, idex_bubble and pc_target_sel are 0; err is 0.
  - pc_target follows ex_target.
- On the edge with rst=1: state becomes RUN, saved target becomes 0x0000, stall_cnt becomes 0.
- Reset asserted in PEND discards the pending redirect.
- Load-use stall lasts exactly one cycle when no other event occurs, because the load leaves EX.
- A redirect costs 2 bubbles with no fetch stall. Under a fetch stall it costs 2 bubbles plus the remaining imem_stall cycles, and the PC loads the target on the cycle imem_stall drops.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> all enables 1, stall_cnt=0, err=0; first non-reset cycle with idle inputs -> default outputs.
- Load-use: ex_is_load=1, ex_rd=3, id_rt=3, id_rt_vld=1 for one cycle -> pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt 0→1. Repeat with id_rt_vld=0 -> no stall.
- Redirect, fetch idle: ex_redirect=1, ex_target=0x0040 -> pc_en=1, pc_target_sel=1, pc_target=0x0040, ifid_flush=1, idex_bubble=1; state stays RUN.
- Redirect under fetch stall: imem_stall=1 for 3 cycles, ex_redirect=1 with target 0x1234 in cycle 1 only, ex_target changes afterward -> pc_en=0 in cycles 1–3. In cycle 4 (imem_stall=0): pc_en=1, pc_target=0x1234, pc_target_sel=1, then RUN.
- Data stall precedence: dmem_stall=1 together with ex_redirect=1 and lu=1 -> all enables 0, no flush or bubble, state unchanged. dmem_stall=1 in PEND -> frozen, remains PEND.
- Saturation: force pc_en=0 for 65 537 cycles -> stall_cnt holds at 0xFFFF; rst -> 0.
